// File: rtl/fb_arb_pkg.sv
// Shared types and widths for the framebuffer access arbiters.
package fb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DRAIN
    } fb_arb_state_t;

    localparam int FB_ADDR_W = 24;
    localparam int FB_DATA_W = 16;
    localparam int FB_MASK_W = 4;
    localparam int GRANT_W   = 3;

endpackage

// File: rtl/fb_arb_rr_picker.sv
// Combinational round-robin picker: first set request after index `last`, wrapping mod NUM_REQ.
module fb_arb_rr_picker
    import fb_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] last,
    output logic               valid,
    output logic [GRANT_W-1:0] grant
);

    // Walk the distances from far to near so the nearest requester is written last and wins.
    always_comb begin
        valid = 1'b0;
        grant = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if ((j == (int'(last) + i) % NUM_REQ) && req[j]) begin
                    valid = 1'b1;
                    grant = GRANT_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/fb_access_arbiter.sv
// Round-robin arbiter in front of the framebuffer single-word access port (clk_pix domain).
// Optional ack watchdog built when FB_ARB_TIMEOUT_EN is defined.
module fb_access_arbiter
    import fb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk_pix,
    input  logic                         reset_i,
    input  logic [NUM_REQ-1:0]           req_sel_i,
    input  logic [NUM_REQ-1:0]           req_wr_i,
    input  logic [FB_MASK_W*NUM_REQ-1:0] req_mask_i,
    input  logic [FB_ADDR_W*NUM_REQ-1:0] req_address_i,
    input  logic [FB_DATA_W*NUM_REQ-1:0] req_data_i,
    output logic [NUM_REQ-1:0]           req_ack_o,
    output logic [FB_DATA_W-1:0]         req_data_o,
    output logic                         fb_sel_o,
    output logic                         fb_wr_o,
    output logic [FB_MASK_W-1:0]         fb_mask_o,
    output logic [FB_ADDR_W-1:0]         fb_address_o,
    output logic [FB_DATA_W-1:0]         fb_data_o,
    input  logic                         fb_ack_i,
    input  logic [FB_DATA_W-1:0]         fb_data_i,
    output logic [GRANT_W-1:0]           grant_id_o,
    output logic                         busy_o,
    output logic                         err_timeout_o
);

    fb_arb_state_t        state;
    logic [GRANT_W-1:0]   last;
    logic                 pick_valid;
    logic [GRANT_W-1:0]   pick_grant;
    logic                 pick_wr;
    logic [FB_MASK_W-1:0] pick_mask;
    logic [FB_ADDR_W-1:0] pick_address;
    logic [FB_DATA_W-1:0] pick_data;
    logic [NUM_REQ-1:0]   ack_onehot;

    fb_arb_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req   (req_sel_i),
        .last  (last),
        .valid (pick_valid),
        .grant (pick_grant)
    );

    always_comb begin
        pick_wr      = 1'b0;
        pick_mask    = '0;
        pick_address = '0;
        pick_data    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant == GRANT_W'(i)) begin
                pick_wr      = req_wr_i[i];
                pick_mask    = req_mask_i[i*FB_MASK_W +: FB_MASK_W];
                pick_address = req_address_i[i*FB_ADDR_W +: FB_ADDR_W];
                pick_data    = req_data_i[i*FB_DATA_W +: FB_DATA_W];
            end
        end
    end

    assign ack_onehot = NUM_REQ'(1) << grant_id_o;
    assign busy_o     = (state != IDLE);

    always_ff @(posedge clk_pix) begin
        if (reset_i) begin
            state        <= IDLE;
            last         <= GRANT_W'(NUM_REQ - 1);
            grant_id_o   <= '0;
            req_ack_o    <= '0;
            req_data_o   <= '0;
            fb_sel_o     <= 1'b0;
            fb_wr_o      <= 1'b0;
            fb_mask_o    <= '0;
            fb_address_o <= '0;
            fb_data_o    <= '0;
        end else begin
            req_ack_o <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        fb_sel_o     <= 1'b1;
                        fb_wr_o      <= pick_wr;
                        fb_mask_o    <= pick_mask;
                        fb_address_o <= pick_address;
                        fb_data_o    <= pick_data;
                        last         <= pick_grant;
                        grant_id_o   <= pick_grant;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (fb_ack_i) begin
                        fb_sel_o   <= 1'b0;
                        req_ack_o  <= ack_onehot;
                        req_data_o <= fb_data_i;
                        state      <= DRAIN;
                    end
                end
                // Wait out the tail of a long ack so the framebuffer sees sel low before re-arming.
                DRAIN: begin
                    if (!fb_ack_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FB_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt;

    // Watchdog only flags; the transaction keeps waiting so the framebuffer FSM stays in step.
    always_ff @(posedge clk_pix) begin
        if (reset_i) begin
            wd_cnt        <= '0;
            err_timeout_o <= 1'b0;
        end else if (state == IDLE) begin
            wd_cnt <= '0;
        end else if (state == BUSY) begin
            if (wd_cnt != 16'hFFFF) begin
                wd_cnt <= wd_cnt + 16'd1;
            end
            if (wd_cnt >= 16'(TIMEOUT_CYCLES - 1)) begin
                err_timeout_o <= 1'b1;
            end
        end
    end
`else
    // Constant 0 for any legal TIMEOUT_CYCLES.
    assign err_timeout_o = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Scoreboard bench for fb_access_arbiter: randomized requester batches, framebuffer responder model.
module tb_fb_access_arbiter;

    localparam int NR = 3;

    typedef struct {
        logic        wr;
        logic [3:0]  mask;
        logic [23:0] addr;
        logic [15:0] data;
    } job_t;

    typedef struct {
        int          id;
        job_t        j;
        logic [15:0] rdata;
    } exp_t;

    logic        clk_pix = 1'b0;
    logic        reset_i;
    logic [2:0]  req_sel_i;
    logic [2:0]  req_wr_i;
    logic [11:0] req_mask_i;
    logic [71:0] req_address_i;
    logic [47:0] req_data_i;
    logic [2:0]  req_ack_o;
    logic [15:0] req_data_o;
    logic        fb_sel_o;
    logic        fb_wr_o;
    logic [3:0]  fb_mask_o;
    logic [23:0] fb_address_o;
    logic [15:0] fb_data_o;
    logic        fb_ack_i;
    logic [15:0] fb_data_i;
    logic [2:0]  grant_id_o;
    logic        busy_o;
    logic        err_timeout_o;

    always #5 clk_pix = ~clk_pix;

    fb_access_arbiter #(
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_pix       (clk_pix),
        .reset_i       (reset_i),
        .req_sel_i     (req_sel_i),
        .req_wr_i      (req_wr_i),
        .req_mask_i    (req_mask_i),
        .req_address_i (req_address_i),
        .req_data_i    (req_data_i),
        .req_ack_o     (req_ack_o),
        .req_data_o    (req_data_o),
        .fb_sel_o      (fb_sel_o),
        .fb_wr_o       (fb_wr_o),
        .fb_mask_o     (fb_mask_o),
        .fb_address_o  (fb_address_o),
        .fb_data_o     (fb_data_o),
        .fb_ack_i      (fb_ack_i),
        .fb_data_i     (fb_data_i),
        .grant_id_o    (grant_id_o),
        .busy_o        (busy_o),
        .err_timeout_o (err_timeout_o)
    );

    int   checks = 0;
    int   errors = 0;
    job_t jobs [NR][$];
    job_t plan [NR][$];
    job_t exp_cmd [$];
    exp_t exp_ack [$];
    logic [15:0] ref_mem [logic [23:0]];
    logic [15:0] fb_mem  [logic [23:0]];
    int   model_last = NR - 1;
    int   fb_lat_fix = -1;
    int   fb_alen_fix = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] preload(input logic [23:0] a);
        return a[15:0] ^ 16'hC3A5;
    endfunction

    function automatic job_t mk(input logic wr, input logic [3:0] m, input logic [23:0] a, input logic [15:0] d);
        job_t j;
        j.wr = wr; j.mask = m; j.addr = a; j.data = d;
        return j;
    endfunction

    // ---------------- reference model ----------------
    task automatic add_job(input int r, input job_t j);
        jobs[r].push_back(j);
        plan[r].push_back(j);
    endtask

    task automatic plan_next(input int r);
        job_t j;
        exp_t e;
        j = plan[r].pop_front();
        e.id = r;
        e.j = j;
        e.rdata = ref_mem.exists(j.addr) ? ref_mem[j.addr] : preload(j.addr);
        if (j.wr) ref_mem[j.addr] = j.data;
        exp_cmd.push_back(j);
        exp_ack.push_back(e);
        model_last = r;
    endtask

    // Pending requesters are served in circular order starting after the last one served.
    task automatic plan_rr();
        int c;
        bit found;
        while (plan[0].size() + plan[1].size() + plan[2].size() > 0) begin
            found = 1'b0;
            for (int k = 1; k <= NR; k++) begin
                c = (model_last + k) % NR;
                if (!found && plan[c].size() > 0) begin
                    plan_next(c);
                    found = 1'b1;
                end
            end
        end
    endtask

    // ---------------- requester driver ----------------
    task automatic load(input int r, input job_t j);
        req_wr_i[r]              = j.wr;
        req_mask_i[r*4 +: 4]     = j.mask;
        req_address_i[r*24 +: 24] = j.addr;
        req_data_i[r*16 +: 16]   = j.data;
    endtask

    task automatic run_batch(input int d0, input int d1, input int d2);
        int ph [NR];
        int dl [NR];
        int cyc;
        bit done;
        dl[0] = d0; dl[1] = d1; dl[2] = d2;
        for (int r = 0; r < NR; r++) ph[r] = 0;
        cyc = 0;
        do begin
            @(posedge clk_pix); #1;
            cyc++;
            done = 1'b1;
            for (int r = 0; r < NR; r++) begin
                case (ph[r])
                    0: begin
                        if (jobs[r].size() == 0) ph[r] = 4;
                        else if (dl[r] == 0) begin
                            load(r, jobs[r].pop_front());
                            req_sel_i[r] = 1'b1;
                            ph[r] = 1;
                        end else dl[r]--;
                    end
                    1: if (req_ack_o[r]) ph[r] = 2;
                    2: begin
                        req_sel_i[r] = 1'b0;
                        ph[r] = (jobs[r].size() > 0) ? 3 : 4;
                    end
                    3: begin
                        load(r, jobs[r].pop_front());
                        req_sel_i[r] = 1'b1;
                        ph[r] = 1;
                    end
                    default: ;
                endcase
                if (ph[r] != 4) done = 1'b0;
            end
        end while (!done && cyc < 2000);
        check("batch_completed", {31'd0, done}, 32'd1);
        req_sel_i = '0;
        repeat (4) @(posedge clk_pix);
        #1;
    endtask

    // ---------------- framebuffer responder ----------------
    initial begin
        int   fst;
        int   lat;
        int   alen;
        logic rst_s;
        logic cw;
        logic [23:0] ca;
        logic [15:0] cd;
        fb_ack_i = 1'b0;
        fb_data_i = '0;
        fst = 0; lat = 0; alen = 0;
        forever begin
            @(posedge clk_pix);
            rst_s = reset_i;
            #1;
            if (rst_s) begin
                fb_ack_i = 1'b0;
                fst = 0;
            end else begin
                case (fst)
                    0: if (fb_sel_o) begin
                        cw = fb_wr_o; ca = fb_address_o; cd = fb_data_o;
                        lat  = (fb_lat_fix  >= 0) ? fb_lat_fix  : int'($urandom_range(0, 3));
                        alen = (fb_alen_fix >= 0) ? fb_alen_fix : int'($urandom_range(1, 2));
                        fst = 1;
                    end
                    2: begin
                        alen--;
                        if (alen == 0) begin
                            fb_ack_i = 1'b0;
                            fst = 0;
                        end
                    end
                    default: ;
                endcase
                if (fst == 1) begin
                    if (lat == 0) begin
                        fb_ack_i = 1'b1;
                        if (cw) begin
                            fb_mem[ca] = cd;
                            fb_data_i = 16'($urandom);
                        end else begin
                            fb_data_i = fb_mem.exists(ca) ? fb_mem[ca] : preload(ca);
                        end
                        fst = 2;
                    end else lat--;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic prev_sel;
        job_t c;
        exp_t e;
        logic [2:0] want;
        prev_sel = 1'b0;
        forever begin
            @(negedge clk_pix);
            if (fb_sel_o && !prev_sel) begin
                check("fb_sel_rise_expected", {31'd0, exp_cmd.size() > 0}, 32'd1);
                if (exp_cmd.size() > 0) begin
                    c = exp_cmd.pop_front();
                    check("fb_wr", {31'd0, fb_wr_o}, {31'd0, c.wr});
                    check("fb_mask", {28'd0, fb_mask_o}, {28'd0, c.mask});
                    check("fb_address", {8'd0, fb_address_o}, {8'd0, c.addr});
                    check("fb_data", {16'd0, fb_data_o}, {16'd0, c.data});
                end
            end
            prev_sel = fb_sel_o;
            if (req_ack_o != 3'd0) begin
                check("ack_expected", {31'd0, exp_ack.size() > 0}, 32'd1);
                if (exp_ack.size() > 0) begin
                    e = exp_ack.pop_front();
                    want = 3'b001 << e.id;
                    check("ack_onehot", {29'd0, req_ack_o}, {29'd0, want});
                    check("ack_grant_id", {29'd0, grant_id_o}, e.id);
                    if (!e.j.wr) check("read_data", {16'd0, req_data_o}, {16'd0, e.rdata});
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_fb_sel"}, {31'd0, fb_sel_o}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        check({tag, "_req_ack"}, {29'd0, req_ack_o}, 32'd0);
        check({tag, "_grant_id"}, {29'd0, grant_id_o}, 32'd0);
        check({tag, "_fb_address"}, {8'd0, fb_address_o}, 32'd0);
        check({tag, "_req_data"}, {16'd0, req_data_o}, 32'd0);
        check({tag, "_err"}, {31'd0, err_timeout_o}, 32'd0);
    endtask

    task automatic pulse_reset();
        reset_i = 1'b1;
        @(posedge clk_pix); #1;
        reset_i = 1'b0;
        model_last = NR - 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout bench did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        job_t j;
        int   n;
        int   w;
        reset_i = 1'b1;
        req_sel_i = '0; req_wr_i = '0; req_mask_i = '0;
        req_address_i = '0; req_data_i = '0;
        ref_mem[24'h0000A0] = 16'h1234;
        fb_mem[24'h0000A0]  = 16'h1234;
        repeat (3) @(posedge clk_pix);
        #1;
        check_all_zero("reset");
        reset_i = 1'b0;

        // All three requesters busy from reset: expect 0,1,2,0,1,2.
        for (int r = 0; r < NR; r++)
            for (int k = 0; k < 2; k++)
                add_job(r, mk(1'b1, 4'hF, 24'h200 + 24'(r*4 + k), 16'($urandom)));
        plan_rr();
        run_batch(0, 0, 0);

        // Single write from requester 1 with a 2-cycle ack.
        fb_lat_fix = 1; fb_alen_fix = 2;
        add_job(1, mk(1'b1, 4'hF, 24'h000100, 16'hBEEF));
        plan_rr();
        run_batch(0, 0, 0);

        // Single read from requester 0 with a 1-cycle ack.
        fb_lat_fix = 0; fb_alen_fix = 1;
        add_job(0, mk(1'b0, 4'hF, 24'h0000A0, 16'h0000));
        plan_rr();
        run_batch(0, 0, 0);

        // Requester 2 arrives during requester 0's transaction; 0 re-requests right away.
        fb_lat_fix = 3; fb_alen_fix = 1;
        add_job(0, mk(1'b0, 4'h3, 24'h000100, 16'h0001));
        add_job(0, mk(1'b1, 4'hC, 24'h000101, 16'h0002));
        add_job(2, mk(1'b0, 4'h5, 24'h000101, 16'h0003));
        plan_next(0); plan_next(2); plan_next(0);
        run_batch(0, 0, 2);

        // Randomized batches.
        fb_lat_fix = -1; fb_alen_fix = -1;
        for (int b = 0; b < 8; b++) begin
            for (int r = 0; r < NR; r++) begin
                n = $urandom_range(0, 3);
                for (int k = 0; k < n; k++) begin
                    w = $urandom_range(0, 1);
                    add_job(r, mk(w[0], 4'($urandom), 24'($urandom_range(0, 7)), 16'($urandom)));
                end
            end
            plan_rr();
            run_batch(0, 0, 0);
        end

        // Reset while requester 1 is in BUSY.
        fb_lat_fix = 8; fb_alen_fix = 1;
        j = mk(1'b0, 4'h9, 24'h000055, 16'h0000);
        exp_cmd.push_back(j);
        load(1, j);
        req_sel_i[1] = 1'b1;
        for (int c = 0; c < 20 && !fb_sel_o; c++) begin
            @(posedge clk_pix); #1;
        end
        check("rst_test_sel_seen", {31'd0, fb_sel_o}, 32'd1);
        repeat (2) @(posedge clk_pix);
        #1;
        check("rst_test_busy", {31'd0, busy_o}, 32'd1);
        reset_i = 1'b1;
        @(posedge clk_pix); #1;
        check_all_zero("midreset");
        reset_i = 1'b0;
        req_sel_i = '0;
        model_last = NR - 1;
        repeat (3) @(posedge clk_pix);
        #1;

        // After reset requester 0 beats requester 2.
        fb_lat_fix = -1; fb_alen_fix = -1;
        add_job(2, mk(1'b0, 4'h1, 24'h000003, 16'h0000));
        add_job(0, mk(1'b0, 4'h2, 24'h000004, 16'h0000));
        plan_rr();
        run_batch(0, 0, 0);

        // Long framebuffer latency: watchdog behaviour.
        fb_lat_fix = 30; fb_alen_fix = 1;
        add_job(0, mk(1'b0, 4'hF, 24'h000006, 16'h0000));
        plan_rr();
        fork
            run_batch(0, 0, 0);
            begin
                for (int c = 0; c < 20 && !fb_sel_o; c++) begin
                    @(posedge clk_pix); #1;
                end
                check("wd_sel_seen", {31'd0, fb_sel_o}, 32'd1);
                repeat (15) @(posedge clk_pix);
                #1;
                check("wd_err_before_limit", {31'd0, err_timeout_o}, 32'd0);
                @(posedge clk_pix); #1;
`ifdef FB_ARB_TIMEOUT_EN
                check("wd_err_at_limit", {31'd0, err_timeout_o}, 32'd1);
`else
                check("wd_err_tied_low", {31'd0, err_timeout_o}, 32'd0);
`endif
            end
        join
`ifdef FB_ARB_TIMEOUT_EN
        check("wd_err_sticky_after_ack", {31'd0, err_timeout_o}, 32'd1);
`else
        check("wd_err_still_low", {31'd0, err_timeout_o}, 32'd0);
`endif
        pulse_reset();
        check("wd_err_after_reset", {31'd0, err_timeout_o}, 32'd0);

        repeat (5) @(posedge clk_pix);
        #1;
        check("cmd_queue_drained", exp_cmd.size(), 32'd0);
        check("ack_queue_drained", exp_ack.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_access_arbiter.md
Name: fb_access_arbiter

Overview:
- Round-robin arbiter sharing the framebuffer single-word access port (sel/wr/mask/address/data/ack) among NUM_REQ requesters, e.g. CPU bus, rasterizer and blitter.
- Sits in the clk_pix domain, directly in front of the framebuffer access port.
- Registers the granted requester's command and holds fb_sel_o until the framebuffer acknowledges.
- Absorbs the framebuffer's multi-cycle ack pulse so that no transaction is issued twice.

Parameters:
- NUM_REQ, 3, number of requesters (2..8); requester 0 wins ties after reset.
- TIMEOUT_CYCLES, 1024, ack watchdog limit; used only with FB_ARB_TIMEOUT_EN.

Ports:
- clk_pix  in  1  pixel clock; the only clock.
- reset_i  in  1  synchronous, active-high reset.
- req_sel_i  in  NUM_REQ  per-requester request.
- req_wr_i  in  NUM_REQ  1 = write, 0 = read.
- req_mask_i  in  4*NUM_REQ  byte/lane mask, packed, requester i at [4i+3:4i].
- req_address_i  in  24*NUM_REQ  word address, packed.
- req_data_i  in  16*NUM_REQ  write data, packed.
- req_ack_o  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- req_data_o  out  16  read data, broadcast, valid with req_ack_o.
- fb_sel_o / fb_wr_o / fb_mask_o[4] / fb_address_o[24] / fb_data_o[16]  out  command to the framebuffer.
- fb_ack_i  in  1  framebuffer ack (may stay high for 1 or 2 cycles).
- fb_data_i  in  16  framebuffer read data.
- grant_id_o  out  3  index of the current or last granted requester (debug).
- busy_o  out  1  high in every state except IDLE.
- err_timeout_o  out  1  sticky watchdog error (tied 0 without the optional feature).

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer last = NUM_REQ-1, so requester 0 has first priority.
- Requester contract:
  - Hold req_sel_i and the payload stable until req_ack_o.
  - Deassert req_sel_i in the cycle after req_ack_o.
- State IDLE:
  - If any req_sel_i is set, pick the first set bit scanning last+1, last+2, … (mod NUM_REQ).
  - Latch wr/mask/address/data into the fb_* registers, set fb_sel_o=1, set last=grant and grant_id_o=grant, go to BUSY.
  - fb_sel_o rises 1 cycle after req_sel_i is sampled.
- State BUSY:
  - Hold fb_sel_o and the payload constant.
  - On fb_ack_i=1: fb_sel_o<=0, req_ack_o[grant]<=1 for one cycle, req_data_o<=fb_data_i (reads; for writes the value is don't-care but is still loaded), go to DRAIN.
- State DRAIN:
  - Stay while fb_ack_i=1; go to IDLE on the first cycle fb_ack_i=0.
  - Minimum 1 cycle. This guarantees the framebuffer sees fb_sel_o=0 while it passes through its own idle, so the command is not re-issued.
- Fairness:
  - A requester holding req_sel_i waits at most NUM_REQ-1 transactions.
  - A new request from the just-served requester loses to any other pending request.
- Request changes: a request asserted or dropped while another is in BUSY has no effect on the current transaction.
- Illegal request withdrawal: if a requester drops req_sel_i before its ack, the transaction still completes and req_ack_o still pulses.
- Reset mid-transaction:
  - Return to IDLE with all outputs 0 in the next cycle.
  - The framebuffer must be reset in the same cycle; the codebase shares reset_i.
- Single-requester throughput: one transaction per (fb latency + 3) cycles.

Optional Feature:
- Macro FB_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - At TIMEOUT_CYCLES, err_timeout_o<=1 (sticky until reset_i).
  - Arbitration continues waiting; there is no abort, because aborting would desynchronise the framebuffer FSM.
- Undefined: no counter is built and err_timeout_o is tied to 0.

Decomposition:
- Package fb_arb_pkg holds:
  - the state enum {IDLE, BUSY, DRAIN};
  - the width constants FB_ADDR_W=24, FB_DATA_W=16, FB_MASK_W=4.
- One sub-module, fb_arb_rr_picker: combinational. Inputs are the request vector and the last index; outputs are a valid bit and the grant index. Reused by later arbiters.

Test Plan:
- Single write, requester 1 (addr 24'h000100, data 16'hBEEF, mask 4'hF), fb ack high 2 cycles → exactly one fb_sel_o assertion, one req_ack_o[1] pulse, never a second fb_sel_o rise during DRAIN.
- Single read, requester 0 (addr 24'h0000A0), fb returns 16'h1234 with a 1-cycle ack → req_data_o=16'h1234 in the same cycle as req_ack_o[0].
- All 3 requesters held continuously from reset → grant order 0,1,2,0,1,2 over 6 transactions; no requester is acked twice in a row.
- Requester 2 asserts while requester 0 is in BUSY and requester 0 re-requests immediately → requester 2 is granted next.
- reset_i pulsed while in BUSY → next cycle fb_sel_o=0, busy_o=0, req_ack_o=0; after reset, requester 0 has priority.
- With FB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, fb_ack_i held 0 → err_timeout_o rises after 16 BUSY cycles, stays high after a late ack, and clears only on reset_i.
